tile_map_arbiter: RTL and testbench



---
 rtl/tile_map_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_tile_map_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tile_map_arbiter
// Purpose  : Shares the single-port tile-map RAM between the VGA renderer,
//            the full-map clear engine and the game logic.
// Revision : 1.0
// ============================================================================
module tile_map_arbiter #(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 4,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
  parameter int                STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              render_req,
  input  logic [ADDR_W-1:0] render_addr,
  output logic              render_valid,
  output logic [DATA_W-1:0] render_type,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  output logic              starve_flag,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [ADDR_W-1:0] clr_cnt_next;
  logic              clear_done_next;

  logic              grant_render;
  logic              grant_clear;
  logic              grant_game;

  logic              cmd_en;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Read tags, bit 0 = renderer, bit 1 = game; s1 follows the command cycle,
  // s2 the cycle in which ram_rdata carries the data.
  logic [1:0]        tag_next;
  logic [1:0]        tag_s1;
  logic [1:0]        tag_s2;

  logic [7:0]        starve_cnt;
  logic [7:0]        starve_cnt_next;

  assign req_ready  = (state == ST_RUN) && !render_req && !rst;
  assign clear_busy = (state == ST_CLEAR);

  always_comb begin
    state_next      = state;
    clr_cnt_next    = clr_cnt;
    clear_done_next = 1'b0;
    grant_render    = render_req;
    grant_clear     = 1'b0;
    grant_game      = 1'b0;

    case (state)
      ST_RUN: begin
        grant_game = req_valid && req_ready;
        if (clear_start) begin
          state_next   = ST_CLEAR;
          clr_cnt_next = '0;
        end
      end
      ST_CLEAR: begin
        // The renderer steals the slot; the clear simply resumes next cycle.
        if (!render_req) begin
          grant_clear  = 1'b1;
          clr_cnt_next = clr_cnt + ADDR_W'(1);
          if (&clr_cnt) begin
            state_next      = ST_RUN;
            clear_done_next = 1'b1;
          end
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_comb begin
    cmd_en    = 1'b0;
    cmd_we    = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    if (grant_render) begin
      cmd_en   = 1'b1;
      cmd_addr = render_addr;
    end else if (grant_clear) begin
      cmd_en    = 1'b1;
      cmd_we    = 1'b1;
      cmd_addr  = clr_cnt;
      cmd_wdata = CLEAR_VALUE;
    end else if (grant_game) begin
      cmd_en    = 1'b1;
      cmd_we    = req_we;
      cmd_addr  = req_addr;
      cmd_wdata = req_wdata;
    end
  end

  assign tag_next = {grant_game && !req_we, grant_render};

  always_comb begin
    starve_cnt_next = starve_cnt;
    if (!req_valid || grant_game) begin
      starve_cnt_next = '0;
    end else if (starve_cnt != 8'hFF) begin
      starve_cnt_next = starve_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      clr_cnt    <= '0;
      clear_done <= 1'b0;
    end else begin
      state      <= state_next;
      clr_cnt    <= clr_cnt_next;
      clear_done <= clear_done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      tag_s1       <= '0;
      tag_s2       <= '0;
      render_valid <= 1'b0;
      render_type  <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      starve_cnt   <= '0;
      starve_flag  <= 1'b0;
    end else begin
      ram_en       <= cmd_en;
      ram_we       <= cmd_we;
      ram_addr     <= cmd_addr;
      ram_wdata    <= cmd_wdata;
      tag_s1       <= tag_next;
      tag_s2       <= tag_s1;
      render_valid <= tag_s2[0];
      rsp_valid    <= tag_s2[1];
      if (tag_s2[0]) begin
        render_type <= ram_rdata;
      end
      if (tag_s2[1]) begin
        rsp_rdata <= ram_rdata;
      end
      starve_cnt  <= starve_cnt_next;
      starve_flag <= ({24'd0, starve_cnt_next} >= 32'(STARVE_LIMIT));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tile_map_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_map_arbiter
// Purpose  : Self-checking bench: RAM model, read scoreboard, directed tests.
// Revision : 1.0
// ============================================================================
module tb_tile_map_arbiter;

  localparam int         ADDR_W       = 8;
  localparam int         DATA_W       = 4;
  localparam logic [3:0] CLEAR_VALUE  = 4'b0000;
  localparam int         STARVE_LIMIT = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              render_req = 1'b0;
  logic [ADDR_W-1:0] render_addr = '0;
  logic              render_valid;
  logic [DATA_W-1:0] render_type;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [DATA_W-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              clear_start = 1'b0;
  logic              clear_busy;
  logic              clear_done;
  logic              starve_flag;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  tile_map_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .CLEAR_VALUE (CLEAR_VALUE),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .render_req  (render_req),
    .render_addr (render_addr),
    .render_valid(render_valid),
    .render_type (render_type),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .starve_flag (starve_flag),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Synchronous single-port RAM: read data one cycle after the command.
  logic [DATA_W-1:0] ram [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Minimal model of the RUN/CLEAR mode, used to predict req_ready.
  logic       m_run = 1'b1;
  logic [7:0] m_cnt = '0;
  always @(posedge clk) begin
    if (rst) begin
      m_run <= 1'b1;
      m_cnt <= '0;
    end else if (m_run) begin
      if (clear_start) begin
        m_run <= 1'b0;
        m_cnt <= '0;
      end
    end else if (!render_req) begin
      m_cnt <= m_cnt + 8'd1;
      if (m_cnt == 8'hFF) m_run <= 1'b1;
    end
  end

  typedef struct {
    int         due;
    logic [3:0] data;
  } exp_t;

  exp_t       rq[$];
  exp_t       gq[$];
  logic [3:0] shadow [256];

  // Scoreboard: pop/compare returning reads, then push reads issued this cycle.
  initial begin
    exp_t e;
    logic exp_ready;
    forever begin
      @(negedge clk);
      exp_ready = m_run && !render_req && !rst;
      check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      check("clear_busy", {31'd0, clear_busy}, {31'd0, !m_run});

      if (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        check("render_valid", {31'd0, render_valid}, 32'd1);
        check("render_type", {28'd0, render_type}, {28'd0, e.data});
      end else begin
        check("render_valid_idle", {31'd0, render_valid}, 32'd0);
      end
      if (gq.size() > 0 && gq[0].due == cyc) begin
        e = gq.pop_front();
        check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("rsp_rdata", {28'd0, rsp_rdata}, {28'd0, e.data});
      end else begin
        check("rsp_valid_idle", {31'd0, rsp_valid}, 32'd0);
      end

      if (!rst) begin
        if (render_req) begin
          e.due  = cyc + 3;
          e.data = shadow[render_addr];
          rq.push_back(e);
        end
        if (req_valid && exp_ready) begin
          if (req_we) begin
            shadow[req_addr] = req_wdata;
          end else begin
            e.due  = cyc + 3;
            e.data = shadow[req_addr];
            gq.push_back(e);
          end
        end
        if (clear_start && m_run) begin
          for (int i = 0; i < 256; i++) shadow[i] = CLEAR_VALUE;
        end
      end
    end
  end

  // Present a game request from posedge+1 until it is accepted.
  task automatic game_op(input logic we, input logic [7:0] addr, input logic [3:0] data);
    logic acc;
    acc       = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    for (int n = 0; n < 500 && !acc; n++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!acc) check("game_timeout", 32'd0, 32'd1);
  endtask

  int n;
  int wr;
  int done_at;
  logic saw_ready;
  logic saw_done;

  initial begin
    // Reset with every input toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      render_req  = 1'($urandom);
      render_addr = 8'($urandom);
      req_valid   = 1'($urandom);
      req_we      = 1'($urandom);
      req_addr    = 8'($urandom);
      req_wdata   = 4'($urandom);
      clear_start = 1'($urandom);
      @(negedge clk);
      check("reset_outputs",
            {4'd0, render_valid, render_type, rsp_valid, rsp_rdata, req_ready, clear_busy,
             clear_done, starve_flag, ram_en, ram_we, ram_addr, ram_wdata}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; render_req = 1'b0; req_valid = 1'b0; clear_start = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; render_addr = '0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Fill some cells
    game_op(1'b1, 8'h35, 4'b1101);
    for (int i = 0; i < 8; i++) game_op(1'b1, 8'(8'h40 + i), 4'($urandom));

    // Single render read of 0x35 with explicit timing
    render_req  = 1'b1;
    render_addr = 8'h35;
    @(posedge clk);
    #1;
    render_req = 1'b0;
    @(negedge clk);
    check("render_cmd", {29'd0, ram_en, ram_we, (ram_addr == 8'h35)}, 32'b101);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("render_ret", {27'd0, render_valid, render_type}, {27'd0, 1'b1, 4'b1101});
    @(negedge clk);
    check("render_pulse", {31'd0, render_valid}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back render reads at full throughput
    for (int i = 0; i < 8; i++) begin
      render_req  = 1'b1;
      render_addr = 8'(8'h40 + i);
      @(posedge clk);
      #1;
    end
    render_req = 1'b0;

    // Game write then read of the same cell on consecutive cycles
    game_op(1'b1, 8'h12, 4'b0001);
    game_op(1'b0, 8'h12, 4'b0000);
    @(negedge clk);
    check("game_rd_cmd", {29'd0, ram_en, ram_we, (ram_addr == 8'h12)}, 32'b101);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("game_rd_ret", {27'd0, rsp_valid, rsp_rdata}, {27'd0, 1'b1, 4'b0001});
    @(posedge clk);
    #1;

    // Renderer and game contend for 3 cycles
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h41;
    for (int i = 0; i < 3; i++) begin
      render_req  = 1'b1;
      render_addr = 8'(8'h44 + i);
      @(negedge clk);
      check("ready_blocked", {31'd0, req_ready}, 32'd0);
      @(posedge clk);
      #1;
    end
    render_req = 1'b0;
    @(negedge clk);
    check("ready_free", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Full clear with 10 render pulses and a stalled game write
    clear_start = 1'b1; render_req = 1'b1; render_addr = 8'h40;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h12; req_wdata = 4'd7;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    n = 0; wr = 0; done_at = -1; saw_ready = 1'b0;
    while (n < 400 && done_at < 0) begin
      render_req  = (n >= 20 && n < 30);
      render_addr = render_req ? 8'(n - 20) : 8'h00;
      @(negedge clk);
      if (ram_en && ram_we) begin
        check("clear_addr", {24'd0, ram_addr}, 32'(wr));
        check("clear_data", {28'd0, ram_wdata}, {28'd0, CLEAR_VALUE});
        wr++;
      end
      if (clear_done) done_at = n;
      else saw_ready = saw_ready | req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    render_req = 1'b0;
    check("clear_writes", 32'(wr), 32'd256);
    check("clear_len", 32'(done_at), 32'd266);
    check("clear_ready", {31'd0, saw_ready}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    check("clear_done_pulse", {31'd0, clear_done}, 32'd0);
    check("stalled_write", {ram_en, ram_we, 2'd0, ram_wdata, 16'd0, ram_addr}, {1'b1, 1'b1, 2'd0, 4'd7, 16'd0, 8'h12});
    @(posedge clk);
    #1;
    game_op(1'b0, 8'h12, 4'd0);
    game_op(1'b0, 8'h40, 4'd0);
    repeat (4) @(posedge clk);
    #1;

    // Reset aborts a clear after 100 writes
    clear_start = 1'b1;
    @(posedge clk);
    #1;
    clear_start = 1'b0;
    wr = 0;
    for (int k = 0; k < 400 && wr < 100; k++) begin
      @(negedge clk);
      if (ram_en && ram_we) wr++;
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (300) begin
      @(negedge clk);
      saw_done = saw_done | clear_done;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);
    check("abort_busy", {31'd0, clear_busy}, 32'd0);
    @(posedge clk);
    #1;

    // Starvation: renderer holds the slot for 70 cycles
    render_req = 1'b1; render_addr = 8'h35;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h44;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk);
      #1;
      if (k == 70) render_req = 1'b0;
      @(negedge clk);
      check($sformatf("starve_%0d", k), {31'd0, starve_flag}, {31'd0, (k >= STARVE_LIMIT)});
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("starve_clear", {31'd0, starve_flag}, 32'd0);

    repeat (6) @(posedge clk);
    #1;
    check("render_queue_empty", 32'(rq.size()), 32'd0);
    check("game_queue_empty", 32'(gq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
